// File: rtl/sqroot_rr_sched.sv
// sqroot_rr_sched: round-robin scheduler sharing one combinational
// floor-square-root unit among NREQ valid/ready requesters, with a single
// registered valid/ready response port carrying the root and winner ID.
// Optional macro SQROOT_SCHED_REM_EN adds the rsp_rem output
// (operand - root*root), registered alongside the root.
module sqroot_rr_sched #(
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_root,
    output logic [IDW-1:0]       rsp_id
`ifdef SQROOT_SCHED_REM_EN
    ,
    output logic [8:0]           rsp_rem
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic           slot_free;
    logic           gnt_any;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] pos;
    logic [15:0]    operand;
    logic [7:0]     sq_root;
`ifdef SQROOT_SCHED_REM_EN
    logic [8:0]     sq_rem;
`endif

    // The response slot can take a new result when empty or being drained;
    // reset forces it closed so nothing is granted while rst_n is low.
    assign slot_free = rst_n && ((state == EMPTY) || rsp_ready);
    assign rsp_valid = (state == FULL);

    // Round-robin search from ptr upwards with wrap; first valid requester wins.
    always_comb begin
        req_ready = '0;
        gnt_any   = 1'b0;
        gnt_id    = '0;
        pos       = '0;
        if (slot_free) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                pos = IDW'((32'(ptr) + k) % NREQ);
                if (!gnt_any && req_valid[pos]) begin
                    gnt_any = 1'b1;
                    gnt_id  = pos;
                end
            end
            if (gnt_any) begin
                req_ready[gnt_id] = 1'b1;
            end
        end
    end

    // Steer the winner's operand into the shared root unit.
    always_comb begin
        operand = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (gnt_id == IDW'(j)) begin
                operand = req_data[16*j +: 16];
            end
        end
    end

    // Shared floor-sqrt unit: restoring digit-by-digit, two operand bits per step.
    always_comb begin : isqrt
        logic [17:0] r;
        logic [15:0] s;
        logic [7:0]  q;
        logic [9:0]  t;
        r = '0;
        s = operand;
        q = '0;
        t = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            r = {r[15:0], s[15:14]};
            s = {s[13:0], 2'b00};
            t = {q, 2'b01};
            if (r >= {8'b0, t}) begin
                r = r - {8'b0, t};
                q = {q[6:0], 1'b1};
            end else begin
                q = {q[6:0], 1'b0};
            end
        end
        sq_root = q;
`ifdef SQROOT_SCHED_REM_EN
        sq_rem  = r[8:0];
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a grant always fills the slot; a drain without grant empties it.
    always_comb begin
        state_nxt = state;
        if (gnt_any) begin
            state_nxt = FULL;
        end else if ((state == FULL) && rsp_ready) begin
            state_nxt = EMPTY;
        end
    end

    // Pointer moves past the winner only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Response registers capture the root and owner on a grant, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_root <= '0;
            rsp_id   <= '0;
`ifdef SQROOT_SCHED_REM_EN
            rsp_rem  <= '0;
`endif
        end else if (gnt_any) begin
            rsp_root <= sq_root;
            rsp_id   <= gnt_id;
`ifdef SQROOT_SCHED_REM_EN
            rsp_rem  <= sq_rem;
`endif
        end
    end

endmodule

// File: tb/tb_sqroot_rr_sched.sv
// Directed bench for sqroot_rr_sched (NREQ=4): vector table plus hand
// sequences for idle, backpressure and asynchronous reset mid-operation.
module tb_sqroot_rr_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_root;
    logic [1:0]  rsp_id;
`ifdef SQROOT_SCHED_REM_EN
    logic [8:0]  rsp_rem;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [63:0] data;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_rv;
        logic [7:0]  exp_root;
        logic [1:0]  exp_id;
        logic [8:0]  exp_rem;
    } vec_t;

    vec_t tbl [16];

    sqroot_rr_sched #(.NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_root  (rsp_root),
        .rsp_id    (rsp_id)
`ifdef SQROOT_SCHED_REM_EN
        ,
        .rsp_rem   (rsp_rem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required normal finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic rv, input logic [7:0] root,
                             input logic [1:0] id, input logic [8:0] rem);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(rv));
        check({tag, " rsp_root"}, 32'(rsp_root), 32'(root));
        check({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
`ifdef SQROOT_SCHED_REM_EN
        check({tag, " rsp_rem"}, 32'(rsp_rem), 32'(rem));
`else
        if (rem != rem) $display("unreachable");
`endif
    endtask

    // Called just after a falling edge: drive, check grant, clock, check response.
    task automatic apply(input vec_t v, input string tag);
        req_valid = v.valid;
        req_data  = v.data;
        rsp_ready = v.rdy;
        #1;
        check({tag, " req_ready"}, 32'(req_ready), 32'(v.exp_ready));
        @(posedge clk);
        @(negedge clk);
        check_rsp(tag, v.exp_rv, v.exp_root, v.exp_id, v.exp_rem);
    endtask

    initial begin
        vec_t v;
        // valid, data {d3,d2,d1,d0}, rsp_ready, exp req_ready, exp rsp_valid/root/id/rem
        tbl[0]  = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd25},       1'b1, 4'b0001, 1'b1, 8'd5,   2'd0, 9'd0};
        tbl[1]  = '{4'b0000, {16'd0, 16'd0, 16'd0, 16'd25},       1'b1, 4'b0000, 1'b0, 8'd5,   2'd0, 9'd0};
        tbl[2]  = '{4'b1000, {16'd65535, 16'd0, 16'd0, 16'd0},    1'b1, 4'b1000, 1'b1, 8'd255, 2'd3, 9'd510};
        tbl[3]  = '{4'b1001, {16'd65535, 16'd0, 16'd0, 16'd0},    1'b1, 4'b0001, 1'b1, 8'd0,   2'd0, 9'd0};
        tbl[4]  = '{4'b1000, {16'd65535, 16'd0, 16'd0, 16'd0},    1'b1, 4'b1000, 1'b1, 8'd255, 2'd3, 9'd510};
        tbl[5]  = '{4'b1111, {16'd65535, 16'd224, 16'd144, 16'd0}, 1'b1, 4'b0001, 1'b1, 8'd0,  2'd0, 9'd0};
        tbl[6]  = '{4'b1110, {16'd65535, 16'd224, 16'd144, 16'd0}, 1'b1, 4'b0010, 1'b1, 8'd12, 2'd1, 9'd0};
        tbl[7]  = '{4'b1100, {16'd65535, 16'd224, 16'd144, 16'd0}, 1'b1, 4'b0100, 1'b1, 8'd14, 2'd2, 9'd28};
        tbl[8]  = '{4'b1000, {16'd65535, 16'd224, 16'd144, 16'd0}, 1'b1, 4'b1000, 1'b1, 8'd255, 2'd3, 9'd510};
        tbl[9]  = '{4'b0000, {16'd65535, 16'd224, 16'd144, 16'd0}, 1'b1, 4'b0000, 1'b0, 8'd255, 2'd3, 9'd510};
        tbl[10] = '{4'b0010, {16'd0, 16'd0, 16'd144, 16'd0},      1'b0, 4'b0010, 1'b1, 8'd12,  2'd1, 9'd0};
        tbl[11] = '{4'b0100, {16'd0, 16'd224, 16'd0, 16'd0},      1'b0, 4'b0000, 1'b1, 8'd12,  2'd1, 9'd0};
        tbl[12] = '{4'b0100, {16'd0, 16'd224, 16'd0, 16'd0},      1'b0, 4'b0000, 1'b1, 8'd12,  2'd1, 9'd0};
        tbl[13] = '{4'b0100, {16'd0, 16'd224, 16'd0, 16'd0},      1'b0, 4'b0000, 1'b1, 8'd12,  2'd1, 9'd0};
        tbl[14] = '{4'b0100, {16'd0, 16'd224, 16'd0, 16'd0},      1'b1, 4'b0100, 1'b1, 8'd14,  2'd2, 9'd28};
        tbl[15] = '{4'b0000, {16'd0, 16'd0, 16'd0, 16'd0},        1'b1, 4'b0000, 1'b0, 8'd14,  2'd2, 9'd28};

        // Reset with requests pending: nothing may be granted.
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = {16'd65535, 16'd224, 16'd144, 16'd0};
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check_rsp("reset", 1'b0, 8'd0, 2'd0, 9'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0000;

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Idle: ten cycles with nothing pending; ptr must stay at 3.
        for (int c = 0; c < 10; c++) begin
            req_valid = 4'b0000;
            rsp_ready = c[0];
            #1;
            check($sformatf("idle%0d req_ready", c), 32'(req_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("idle%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
        end
        v = '{4'b1001, {16'd65535, 16'd0, 16'd0, 16'd25}, 1'b1, 4'b1000, 1'b1, 8'd255, 2'd3, 9'd510};
        apply(v, "post_idle");
        v = '{4'b0010, {16'd0, 16'd0, 16'd99, 16'd0}, 1'b1, 4'b0010, 1'b1, 8'd9, 2'd1, 9'd18};
        apply(v, "pre_rst");
        v = '{4'b1010, {16'd100, 16'd0, 16'd99, 16'd0}, 1'b0, 4'b0000, 1'b1, 8'd9, 2'd1, 9'd18};
        apply(v, "held");

        // Asynchronous reset between edges discards the held response.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst req_ready", 32'(req_ready), 32'd0);
        check_rsp("midrst", 1'b0, 8'd0, 2'd0, 9'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("inrst req_ready", 32'(req_ready), 32'd0);
        check("inrst rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("release req_ready", 32'(req_ready), 32'b0010);
        @(posedge clk);
        @(negedge clk);
        check_rsp("release", 1'b1, 8'd9, 2'd1, 9'd18);
        req_valid = 4'b0000;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
